// File: rtl/decade_counter_pkg.sv
// Shared defaults and count type for the decade counter.
package decade_counter_pkg;
  localparam int CNT_W   = 4;
  localparam int MAX_CNT = 9;

  typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/decade_counter.sv
// Modulo-(MAX_CNT+1) up-counter with count enable and async active-low reset.
// Optional terminal-count output tc is built only with DECADE_CNT_TC_EN defined.
module decade_counter
  import decade_counter_pkg::*;
#(
  parameter int CNT_W   = decade_counter_pkg::CNT_W,
  parameter int MAX_CNT = decade_counter_pkg::MAX_CNT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
`ifdef DECADE_CNT_TC_EN
  ,
  output logic             tc
`endif
);

  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_CNT);

  if ((2 ** CNT_W) <= MAX_CNT) begin : g_bad_width
    $error("decade_counter: CNT_W too narrow for MAX_CNT");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // >= also recovers an out-of-range count to 0 on the next enabled edge
  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      if (cnt_q >= MAX_V) cnt_d = '0;
      else                cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

`ifdef DECADE_CNT_TC_EN
  // High in the cycle before the wrap; feeds the en of the next digit.
  assign tc = en & (cnt_q == MAX_V);
`endif

`ifndef SYNTHESIS
  a_cnt_range: assert property (@(posedge clk) disable iff (!rst) cnt_q <= MAX_V)
    else $error("decade_counter: cnt out of range");
  a_en_known: assert property (@(posedge clk) disable iff (!rst) !$isunknown(en))
    else $error("decade_counter: en unknown while out of reset");
`endif

endmodule

// File: tb/tb_decade_counter.sv
// Scoreboard bench for decade_counter; covers tc when DECADE_CNT_TC_EN is defined.
module tb_decade_counter;
  import decade_counter_pkg::*;

  logic clk, rst, en;
  cnt_t cnt;
`ifdef DECADE_CNT_TC_EN
  logic tc;
`endif

  int errors = 0;
  int checks = 0;
  int model  = 0;
  cnt_t exp_q[$];

  decade_counter dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .cnt (cnt)
`ifdef DECADE_CNT_TC_EN
    ,
    .tc  (tc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive en at negedge, push the model's expected count, compare after the edge.
  task automatic step(input logic e, input string name);
    cnt_t exp;
    @(negedge clk);
    en = e;
    if (e) model = (model == MAX_CNT) ? 0 : model + 1;
    exp_q.push_back(cnt_t'(model));
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (cnt !== exp) begin
      errors++;
      $display("FAIL %s: cnt=%0d expected=%0d", name, cnt, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (cnt !== '0) begin
        errors++;
        $display("FAIL reset_hold: cnt=%0d expected=0", cnt);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    model = 0;
    step(1'b0, "release_idle");
    step(1'b0, "release_idle2");
  endtask

  task automatic test_count_wrap();
    for (int i = 0; i < 12; i++) step(1'b1, "count_wrap");
  endtask

  task automatic test_hold();
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, "hold_to5");
    for (int i = 0; i < 4; i++) step(1'b0, "hold5");
    step(1'b1, "hold_resume");
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1, "arst_to7");
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (cnt !== '0) begin
      errors++;
      $display("FAIL arst_immediate: cnt=%0d expected=0", cnt);
    end
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (cnt !== '0) begin
        errors++;
        $display("FAIL arst_hold: cnt=%0d expected=0", cnt);
      end
    end
    @(negedge clk);
    en  = 1'b0;
    rst = 1'b1;
    model = 0;
    step(1'b1, "arst_restart");
  endtask

`ifdef DECADE_CNT_TC_EN
  task automatic test_tc();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      en = 1'b1;
      #1;
      checks++;
      if (tc !== (model == MAX_CNT)) begin
        errors++;
        $display("FAIL tc_en1: tc=%0b expected=%0b cnt=%0d", tc, (model == MAX_CNT), cnt);
      end
      step(1'b1, "tc_count");
    end
    while (model != MAX_CNT) step(1'b1, "tc_to9");
    @(negedge clk);
    en = 1'b0;
    #1;
    checks++;
    if (tc !== 1'b0) begin
      errors++;
      $display("FAIL tc_en0: tc=%0b expected=0", tc);
    end
    step(1'b0, "tc_hold9");
    step(1'b1, "tc_wrap");
  endtask
`endif

  task automatic test_free_run();
    int   wraps;
    cnt_t prev;
    do_reset();
    wraps = 0;
    prev  = cnt;
    for (int i = 0; i < 100; i++) begin
      step(1'b1, "free_run");
      if (prev == cnt_t'(MAX_CNT) && cnt == '0) wraps++;
      prev = cnt;
    end
    checks++;
    if (wraps != 10 || cnt !== '0) begin
      errors++;
      $display("FAIL free_run_wraps: wraps=%0d cnt=%0d expected wraps=10 cnt=0", wraps, cnt);
    end
  endtask

  initial begin
    rst = 1'b0;
    en  = 1'b0;
    test_reset();
    test_count_wrap();
    test_hold();
    test_async_reset();
`ifdef DECADE_CNT_TC_EN
    test_tc();
`endif
    test_free_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim did not finish");
    $fatal(1);
  end

endmodule
